// File: rtl/interrupt_sequencer_pkg.sv
// Shared definitions for the interrupt entry sequencer: state and source
// encodings, default vectors and the status bit positions touched on entry.
package interrupt_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PUSH_PCH  = 3'd1,
        ST_PUSH_PCL  = 3'd2,
        ST_PUSH_STAT = 3'd3,
        ST_VEC_LO    = 3'd4,
        ST_VEC_HI    = 3'd5,
        ST_LOAD_PC   = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        SRC_RESET = 2'd0,
        SRC_NMI   = 2'd1,
        SRC_BRK   = 2'd2,
        SRC_IRQ   = 2'd3
    } src_t;

    localparam logic [15:0] DEFAULT_STACK_BASE   = 16'h0100;
    localparam logic [15:0] DEFAULT_NMI_VECTOR   = 16'hFFFA;
    localparam logic [15:0] DEFAULT_RESET_VECTOR = 16'hFFFC;
    localparam logic [15:0] DEFAULT_IRQ_VECTOR   = 16'hFFFE;

    localparam int STAT_I    = 2;
    localparam int STAT_B    = 4;
    localparam int STAT_BIT5 = 5;

    function automatic logic is_push_state(input state_t s);
        return (s == ST_PUSH_PCH) || (s == ST_PUSH_PCL) || (s == ST_PUSH_STAT);
    endfunction

    // Pushed status always has bit 5 set; B distinguishes BRK from hardware entries.
    function automatic logic [7:0] pushed_status(input logic [7:0] status, input logic is_brk);
        logic [7:0] s;
        s            = status;
        s[STAT_BIT5] = 1'b1;
        s[STAT_B]    = is_brk;
        return s;
    endfunction

endpackage

// File: rtl/interrupt_sequencer_nmi_edge_detect.sv
// NMI falling-edge detector with a pending latch; a new edge wins over a
// simultaneous clear so that no NMI is lost.
module interrupt_sequencer_nmi_edge_detect (
    input  logic clk,
    input  logic reset_n,
    input  logic nmi_n,
    input  logic clear,
    output logic pending
);

    logic nmi_n_reg;
    logic pending_reg;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            nmi_n_reg   <= 1'b1;
            pending_reg <= 1'b0;
        end else begin
            nmi_n_reg <= nmi_n;
            if (nmi_n_reg && !nmi_n) begin
                pending_reg <= 1'b1;
            end else if (clear) begin
                pending_reg <= 1'b0;
            end
        end
    end

    assign pending = pending_reg;

endmodule

// File: rtl/interrupt_sequencer.sv
// Arbitrates reset/NMI/BRK/IRQ and walks the datapath through the 6502
// entry sequence: three pushes, two vector fetches and a PC load.
module interrupt_sequencer
    import interrupt_sequencer_pkg::*;
#(
    parameter logic [15:0] STACK_BASE   = DEFAULT_STACK_BASE,
    parameter logic [15:0] NMI_VECTOR   = DEFAULT_NMI_VECTOR,
    parameter logic [15:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter logic [15:0] IRQ_VECTOR   = DEFAULT_IRQ_VECTOR
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        irq_n,
    input  logic        nmi_n,
    input  logic        brk_req,
    input  logic        instruction_done,
    input  logic        i_flag,
    input  logic [15:0] pc_in,
    input  logic [7:0]  sp_in,
    input  logic [7:0]  status_in,
    input  logic [7:0]  data_in,
    output logic        busy,
    output logic [15:0] addr_out,
    output logic [7:0]  data_out,
    output logic        mem_we,
    output logic        sp_dec,
    output logic        pc_we,
    output logic [15:0] pc_out,
    output logic        set_i
);

    state_t      state_reg, state_next;
    src_t        src_reg, src_next;
    logic [15:0] vector_reg, vector_next;
    logic        reset_pending_reg;
    logic        busy_reg, mem_we_reg, sp_dec_reg, pc_we_reg, set_i_reg;
    logic [15:0] pc_out_reg;
    logic        nmi_pending;
    logic        nmi_clear;
    logic        irq_req;

    assign irq_req   = !irq_n && !i_flag;
    assign nmi_clear = (state_next == ST_VEC_LO) && (src_reg == SRC_NMI);

    interrupt_sequencer_nmi_edge_detect u_nmi_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .nmi_n   (nmi_n),
        .clear   (nmi_clear),
        .pending (nmi_pending)
    );

    always_comb begin
        state_next  = state_reg;
        src_next    = src_reg;
        vector_next = vector_reg;
        case (state_reg)
            ST_IDLE: begin
                if (reset_pending_reg) begin
                    state_next  = ST_PUSH_PCH;
                    src_next    = SRC_RESET;
                    vector_next = RESET_VECTOR;
                end else if (instruction_done) begin
                    if (nmi_pending) begin
                        state_next  = ST_PUSH_PCH;
                        src_next    = SRC_NMI;
                        vector_next = NMI_VECTOR;
                    end else if (brk_req) begin
                        state_next  = ST_PUSH_PCH;
                        src_next    = SRC_BRK;
                        vector_next = IRQ_VECTOR;
                    end else if (irq_req) begin
                        state_next  = ST_PUSH_PCH;
                        src_next    = SRC_IRQ;
                        vector_next = IRQ_VECTOR;
                    end
                end
            end
            ST_PUSH_PCH:  state_next = ST_PUSH_PCL;
            ST_PUSH_PCL:  state_next = ST_PUSH_STAT;
            ST_PUSH_STAT: state_next = ST_VEC_LO;
            ST_VEC_LO:    state_next = ST_VEC_HI;
            ST_VEC_HI:    state_next = ST_LOAD_PC;
            default:      state_next = ST_IDLE;
        endcase
    end

    // Strobes are decoded from the next state so they line up with state_reg.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg         <= ST_IDLE;
            src_reg           <= SRC_RESET;
            vector_reg        <= RESET_VECTOR;
            reset_pending_reg <= 1'b1;
            busy_reg          <= 1'b0;
            mem_we_reg        <= 1'b0;
            sp_dec_reg        <= 1'b0;
            pc_we_reg         <= 1'b0;
            set_i_reg         <= 1'b0;
            pc_out_reg        <= 16'h0000;
        end else begin
            state_reg  <= state_next;
            src_reg    <= src_next;
            vector_reg <= vector_next;
            busy_reg   <= (state_next != ST_IDLE);
            mem_we_reg <= is_push_state(state_next) && (src_next != SRC_RESET);
            sp_dec_reg <= is_push_state(state_next);
            pc_we_reg  <= (state_next == ST_LOAD_PC);
            set_i_reg  <= (state_next == ST_LOAD_PC);
            if (state_reg == ST_VEC_LO) begin
                pc_out_reg[7:0] <= data_in;
            end
            if (state_reg == ST_VEC_HI) begin
                pc_out_reg[15:8] <= data_in;
            end
            if (state_reg == ST_LOAD_PC) begin
                reset_pending_reg <= 1'b0;
            end
        end
    end

    // Address and write data follow the live SP/PC/status so each push sees
    // the SP value the stack register holds in that very cycle.
    always_comb begin
        addr_out = 16'h0000;
        data_out = 8'h00;
        case (state_reg)
            ST_PUSH_PCH: begin
                addr_out = STACK_BASE + {8'h00, sp_in};
                data_out = pc_in[15:8];
            end
            ST_PUSH_PCL: begin
                addr_out = STACK_BASE + {8'h00, sp_in};
                data_out = pc_in[7:0];
            end
            ST_PUSH_STAT: begin
                addr_out = STACK_BASE + {8'h00, sp_in};
                data_out = pushed_status(status_in, src_reg == SRC_BRK);
            end
            ST_VEC_LO: addr_out = vector_reg;
            ST_VEC_HI: addr_out = vector_reg + 16'd1;
            default: begin
                addr_out = 16'h0000;
                data_out = 8'h00;
            end
        endcase
    end

    assign busy   = busy_reg;
    assign mem_we = mem_we_reg;
    assign sp_dec = sp_dec_reg;
    assign pc_we  = pc_we_reg;
    assign set_i  = set_i_reg;
    assign pc_out = pc_out_reg;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed plus randomized checks of the interrupt entry sequencer against
// a cycle-list model of each entry sequence and a priority-rule arbiter.
module tb_interrupt_sequencer;

    localparam int SRC_RESET = 0;
    localparam int SRC_NMI   = 1;
    localparam int SRC_BRK   = 2;
    localparam int SRC_IRQ   = 3;

    logic        clk;
    logic        reset_n;
    logic        irq_n;
    logic        nmi_n;
    logic        brk_req;
    logic        instruction_done;
    logic        i_flag;
    logic [15:0] pc_in;
    logic [7:0]  sp_in;
    logic [7:0]  status_in;
    logic [7:0]  data_in;
    logic        busy;
    logic [15:0] addr_out;
    logic [7:0]  data_out;
    logic        mem_we;
    logic        sp_dec;
    logic        pc_we;
    logic [15:0] pc_out;
    logic        set_i;

    int checks_total  = 0;
    int checks_passed = 0;
    int checks_failed = 0;
    bit nmi_pend      = 1'b0;

    logic [7:0]  vec_mem [0:7];
    logic [15:0] rd_off;
    string       src_name [4] = '{"reset", "nmi", "brk", "irq"};

    interrupt_sequencer dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .irq_n            (irq_n),
        .nmi_n            (nmi_n),
        .brk_req          (brk_req),
        .instruction_done (instruction_done),
        .i_flag           (i_flag),
        .pc_in            (pc_in),
        .sp_in            (sp_in),
        .status_in        (status_in),
        .data_in          (data_in),
        .busy             (busy),
        .addr_out         (addr_out),
        .data_out         (data_out),
        .mem_we           (mem_we),
        .sp_dec           (sp_dec),
        .pc_we            (pc_we),
        .pc_out           (pc_out),
        .set_i            (set_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: vector page FFFA..FFFF from vec_mem, everything else reads EA.
    always_comb begin
        rd_off  = addr_out - 16'hFFFA;
        data_in = (addr_out >= 16'hFFFA) ? vec_mem[rd_off[2:0]] : 8'hEA;
    end

    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        logic [15:0] off;
        off = a - 16'hFFFA;
        return (a >= 16'hFFFA) ? vec_mem[off[2:0]] : 8'hEA;
    endfunction

    function automatic logic [15:0] vec_of(input int src);
        if (src == SRC_RESET) return 16'hFFFC;
        if (src == SRC_NMI)   return 16'hFFFA;
        return 16'hFFFE;
    endfunction

    function automatic int winner(input bit rst, input bit nmi, input bit brk, input bit irq_low, input bit imask);
        if (rst) return SRC_RESET;
        if (nmi) return SRC_NMI;
        if (brk) return SRC_BRK;
        if (irq_low && !imask) return SRC_IRQ;
        return -1;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks_total++;
        assert (obs === exp) begin
            checks_passed++;
        end else begin
            checks_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, 64'({busy, mem_we, sp_dec, pc_we, set_i, addr_out, data_out, pc_out}), 64'd0);
    endtask

    // Caller arms the trigger at a negedge; the sequence must show up at the
    // very next negedge and last exactly six busy cycles.
    task automatic run_seq(input int src, input int inject, input int inj_k);
        logic [15:0] vec;
        logic [7:0]  st_exp;
        logic [15:0] stack_addr;
        logic        push;
        logic        we;
        vec        = vec_of(src);
        st_exp     = (status_in & 8'hEF) | 8'h20 | ((src == SRC_BRK) ? 8'h10 : 8'h00);
        stack_addr = 16'h0100 + {8'h00, sp_in};
        for (int k = 0; k < 6; k++) begin
            tick();
            if (k == 1) instruction_done = 1'b0;
            if (inject == 3 && k == inj_k + 1) instruction_done = 1'b0;
            if (inject == 1 && k == inj_k + 1) nmi_n = 1'b1;
            push = (k < 3);
            we   = push && (src != SRC_RESET);
            check($sformatf("%s_ctl_k%0d", src_name[src], k),
                  64'({busy, mem_we, sp_dec, pc_we, set_i}),
                  64'({1'b1, we, push, k == 5, k == 5}));
            if (push)
                check($sformatf("%s_addr_k%0d", src_name[src], k), 64'(addr_out), 64'(stack_addr));
            else if (k == 3)
                check($sformatf("%s_addr_lo", src_name[src]), 64'(addr_out), 64'(vec));
            else if (k == 4)
                check($sformatf("%s_addr_hi", src_name[src]), 64'(addr_out), 64'(vec + 16'd1));
            if (we) begin
                if (k == 0) check($sformatf("%s_pch", src_name[src]), 64'(data_out), 64'(pc_in[15:8]));
                if (k == 1) check($sformatf("%s_pcl", src_name[src]), 64'(data_out), 64'(pc_in[7:0]));
                if (k == 2) check($sformatf("%s_stat", src_name[src]), 64'(data_out), 64'(st_exp));
            end
            if (k == 5)
                check($sformatf("%s_pc_out", src_name[src]), 64'(pc_out),
                      64'({mem_byte(vec + 16'd1), mem_byte(vec)}));
            if (k == inj_k) begin
                if (inject == 1) begin
                    nmi_n    = 1'b0;
                    nmi_pend = 1'b1;
                end else if (inject == 3) begin
                    instruction_done = 1'b1;
                end else if (inject == 2) begin
                    reset_n = 1'b0;
                    tick();
                    check_all_zero("abort_outputs_zero");
                    reset_n          = 1'b1;
                    instruction_done = 1'b0;
                    nmi_pend         = 1'b0;
                    return;
                end
            end
        end
        tick();
        instruction_done = 1'b0;
        check($sformatf("%s_end_idle", src_name[src]), 64'({busy, mem_we, sp_dec, pc_we, set_i}), 64'd0);
    endtask

    task automatic expect_idle(input string tag);
        tick();
        instruction_done = 1'b0;
        check(tag, 64'(busy), 64'd0);
        tick();
        check({tag, "_2"}, 64'(busy), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        bit want_nmi;
        reset_n          = 1'b0;
        irq_n            = 1'b1;
        nmi_n            = 1'b1;
        brk_req          = 1'b0;
        instruction_done = 1'b0;
        i_flag           = 1'b0;
        pc_in            = 16'h0000;
        sp_in            = 8'hFD;
        status_in        = 8'h00;
        for (int i = 0; i < 8; i++) vec_mem[i] = 8'($urandom);
        vec_mem[2] = 8'h34;
        vec_mem[3] = 8'h12;

        // Reset state and the power-on reset sequence.
        tick(); tick(); tick();
        check_all_zero("reset_state");
        reset_n = 1'b1;
        run_seq(SRC_RESET, 0, 0);
        check("reset_pc_1234", 64'(pc_out), 64'h1234);
        expect_idle("reset_runs_once");

        // Unmasked IRQ.
        pc_in = 16'hC123; sp_in = 8'hFD; status_in = 8'h00;
        irq_n = 1'b0; i_flag = 1'b0; instruction_done = 1'b1;
        run_seq(SRC_IRQ, 0, 0);
        irq_n = 1'b1;

        // Masked IRQ is not taken.
        irq_n = 1'b0; i_flag = 1'b1; instruction_done = 1'b1;
        expect_idle("irq_masked");
        irq_n = 1'b1; i_flag = 1'b0;

        // BRK at SP=00, with a mid-sequence boundary that must be ignored.
        pc_in = 16'h4002; sp_in = 8'h00; status_in = 8'h01;
        brk_req = 1'b1; instruction_done = 1'b1;
        run_seq(SRC_BRK, 3, 2);
        brk_req = 1'b0;

        // NMI edge during an IRQ sequence stays pending until the next boundary.
        sp_in = 8'hFF; pc_in = 16'h8123;
        irq_n = 1'b0; instruction_done = 1'b1;
        run_seq(SRC_IRQ, 1, 1);
        irq_n = 1'b1;
        check("nmi_waits_for_boundary", 64'(busy), 64'd0);
        instruction_done = 1'b1;
        nmi_pend = 1'b0;
        run_seq(SRC_NMI, 0, 0);
        instruction_done = 1'b1;
        expect_idle("nmi_pending_cleared");

        // NMI and IRQ at the same boundary: NMI first, then the still-held IRQ.
        irq_n = 1'b0; nmi_n = 1'b0;
        tick();
        nmi_n = 1'b1;
        instruction_done = 1'b1;
        run_seq(SRC_NMI, 0, 0);
        instruction_done = 1'b1;
        run_seq(SRC_IRQ, 0, 0);

        // Reset asserted in PUSH_STAT aborts and restarts a full reset sequence.
        instruction_done = 1'b1;
        run_seq(SRC_IRQ, 2, 2);
        irq_n = 1'b1;
        run_seq(SRC_RESET, 0, 0);

        // Randomized requests at instruction boundaries.
        for (int it = 0; it < 30; it++) begin
            want_nmi  = ($urandom_range(0, 3) == 0);
            brk_req   = ($urandom_range(0, 3) == 0);
            irq_n     = ($urandom_range(0, 1) == 1);
            i_flag    = ($urandom_range(0, 1) == 1);
            pc_in     = 16'($urandom);
            sp_in     = 8'($urandom);
            status_in = 8'($urandom);
            for (int i = 0; i < 8; i++) vec_mem[i] = 8'($urandom);
            if (want_nmi) begin
                nmi_n    = 1'b0;
                nmi_pend = 1'b1;
                tick();
                nmi_n = 1'b1;
            end
            w = winner(1'b0, nmi_pend, brk_req, !irq_n, i_flag);
            instruction_done = 1'b1;
            if (w < 0) begin
                expect_idle($sformatf("rand_idle_%0d", it));
            end else begin
                if (w == SRC_NMI) nmi_pend = 1'b0;
                run_seq(w, 0, 0);
            end
            brk_req = 1'b0;
            irq_n   = 1'b1;
            tick();
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
